// File: rtl/pico_io_pkg.sv
// Shared constants and types for the board-test I/O conditioning blocks.
// Used by both the switch conditioner and its per-bit debounce slice.
package pico_io_pkg;

    localparam int SW_WIDTH          = 10;
    localparam int LED_WIDTH         = 8;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 4;

    typedef enum logic {IDLE, PENDING} filt_state_t;

    // Width of the per-bit filter counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, consecutive-sample filter FSM,
// registered stable level and one-cycle rise/fall strobes.
module sw_debounce_bit
    import pico_io_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic strobe_en,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    filt_state_t            state;
    logic                   s;
    logic                   accept;

    assign s = sync[SYNC_STAGES-1];

    // IDLE always holds the counter at zero, so a differing sample there is
    // only accepted outright when a single sample is enough.
    always_comb begin
        accept = 1'b0;
        if (s != stable)
            accept = (state == IDLE) ? (CNT_LAST == '0) : (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            state  <= IDLE;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (accept) begin
                stable <= s;
                rise   <= s & strobe_en;
                fall   <= ~s & strobe_en;
                cnt    <= '0;
                state  <= IDLE;
            end else if (s != stable) begin
                cnt    <= cnt + 1'b1;
                state  <= PENDING;
            end else begin
                cnt    <= '0;
                state  <= IDLE;
            end
        end
    end

endmodule

// File: rtl/sw_conditioner.sv
// Slide-switch conditioner feeding the processor SW input: per-bit debounce
// slices plus a post-reset settle counter that gates the edge strobes.
module sw_conditioner
    import pico_io_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_valid
);

    localparam int            SETTLE = SYNC_STAGES + STABLE_CYCLES;
    localparam int            SCW    = $clog2(SETTLE + 1);
    localparam logic [SCW-1:0] SETTLE_MAX  = SCW'(SETTLE);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

    logic [SCW-1:0] settle_cnt;

    // Saturates at SETTLE so sw_valid stays high until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            sw_valid   <= 1'b0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST)
                sw_valid <= 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .raw      (sw_raw[i]),
            .strobe_en(sw_valid),
            .stable   (sw_stable[i]),
            .rise     (sw_rise[i]),
            .fall     (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner: directed scenarios plus random
// switch activity, compared against a sample-history reference model.
module tb_sw_conditioner;

    localparam int W  = 10;
    localparam int SS = 2;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_valid;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] m_stable, m_rise, m_fall;
    logic         m_valid;
    int           ecnt;
    int           dc [W];
    logic [W-1:0] hist [$];
    int           rise3_seen;

    sw_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_stable(sw_stable),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .sw_valid (sw_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; the model sees the raw value that
    // the switch pins held across that edge, delayed SS samples.
    task automatic step(input logic [W-1:0] raw, input logic rst);
        logic [W-1:0] smp;
        logic         pv;
        sw_raw = raw;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            for (int k = 0; k < SS; k++) hist.push_back('0);
            m_stable = '0; m_rise = '0; m_fall = '0; m_valid = 1'b0; ecnt = 0;
            for (int i = 0; i < W; i++) dc[i] = 0;
        end else begin
            pv  = m_valid;
            smp = hist.pop_front();
            hist.push_back(raw);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (smp[i] != m_stable[i]) begin
                    dc[i]++;
                    if (dc[i] == SC) begin
                        m_stable[i] = smp[i];
                        dc[i] = 0;
                        if (pv) begin
                            if (smp[i]) m_rise[i] = 1'b1;
                            else        m_fall[i] = 1'b1;
                        end
                    end
                end else begin
                    dc[i] = 0;
                end
            end
            ecnt++;
            if (ecnt >= SS + SC) m_valid = 1'b1;
        end
        #1;
        if (sw_rise[3]) rise3_seen++;
        chk("stable", 32'(sw_stable), 32'(m_stable));
        chk("rise",   32'(sw_rise),   32'(m_rise));
        chk("fall",   32'(sw_fall),   32'(m_fall));
        chk("valid",  32'(sw_valid),  32'(m_valid));
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] bounce;
        bounce = 10'b0001110111;   // bit k is sample k of the bit-3 bounce

        // 1: clean rise on bit 0 after settling
        step('0, 1'b1); step('0, 1'b1);
        chk("reset_stable", 32'(sw_stable), 32'h0);
        chk("reset_valid",  32'(sw_valid),  32'h0);
        repeat (10) step('0, 1'b0);
        repeat (5) step(10'h001, 1'b0);
        chk("rise_lat_before", 32'(sw_stable), 32'h0);
        step(10'h001, 1'b0);
        chk("rise_lat_stable", 32'(sw_stable), 32'h001);
        chk("rise_lat_strobe", 32'(sw_rise),   32'h001);
        step(10'h001, 1'b0);
        chk("rise_one_cycle",  32'(sw_rise),   32'h0);

        // 2: 3-cycle glitch on bit 5 is rejected
        repeat (3) step(10'h021, 1'b0);
        repeat (8) step(10'h001, 1'b0);
        chk("glitch_stable", 32'(sw_stable), 32'h001);

        // 3: switches held high through reset
        step(10'h3FF, 1'b1); step(10'h3FF, 1'b1);
        repeat (5) step(10'h3FF, 1'b0);
        chk("held_valid_e5", 32'(sw_valid), 32'h0);
        step(10'h3FF, 1'b0);
        chk("held_valid_e6",  32'(sw_valid),  32'h1);
        chk("held_stable_e6", 32'(sw_stable), 32'h3FF);
        chk("held_no_rise",   32'(sw_rise),   32'h0);

        // 4: simultaneous rise and fall
        repeat (10) step(10'h004, 1'b0);
        repeat (5) step(10'h002, 1'b0);
        step(10'h002, 1'b0);
        chk("swap_rise", 32'(sw_rise), 32'h002);
        chk("swap_fall", 32'(sw_fall), 32'h004);

        // 5: bounce on bit 3
        rise3_seen = 0;
        for (int k = 0; k < 7; k++) step(10'h002 | (W'(bounce[k]) << 3), 1'b0);
        repeat (10) step(10'h00A, 1'b0);
        chk("bounce_one_rise", 32'(rise3_seen), 32'd1);
        chk("bounce_stable",   32'(sw_stable),  32'h00A);

        // 6: reset in the middle of a pending transition
        repeat (10) step(10'h000, 1'b0);
        repeat (SS + 3) step(10'h010, 1'b0);
        step(10'h010, 1'b1);
        chk("midreset_stable", 32'(sw_stable), 32'h0);
        chk("midreset_valid",  32'(sw_valid),  32'h0);
        repeat (5) step(10'h010, 1'b0);
        chk("midreset_valid_e5", 32'(sw_valid), 32'h0);
        step(10'h010, 1'b0);
        chk("midreset_valid_e6", 32'(sw_valid), 32'h1);

        // 7: random switch activity with occasional resets
        r = 10'h010;
        for (int n = 0; n < 600; n++) begin
            r = r ^ W'($urandom & $urandom & $urandom);
            step(r, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
